i2c_slave_regfile: RTL and testbench

- Second-generation I2C target, sampled entirely in the system clock domain. SCL/SDA are oversampled, synchronised and glitch-filtered; no logic is clocked by SCL.
- Exposes a parametrised 8-bit register file over the standard pointer-then-data protocol, with auto-increment, repeated START support, and a fabric-side read port and write strobe.
- Sits between the chip's I2C pads (open-drain via sda_oe) and local control logic.

---
 rtl/i2c_slave_regfile.sv | 190 +++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: clk-domain oversampled I2C target exposing an 8-bit register file with pointer auto-increment.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h57,
  parameter int NUM_REGS = 16,
  parameter int FILTER_LEN = 3,
  parameter logic [7:0] RESET_VAL = 8'h00,
  localparam int PTR_W = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic [PTR_W-1:0] host_raddr,
  output logic [7:0]       host_rdata,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);
  typedef enum logic [3:0] {IDLE, ADDR, ACK_A, PTR, ACK_P, WDATA, ACK_W, RDATA, MACK} state_t;
  state_t state, state_n;
  logic [1:0] sync1, sync2, filt, filt_q;
  logic [2:0] cnt [2];
  logic [7:0] regs [NUM_REGS];
  logic [7:0] shreg, shreg_n, rd_byte, wr_data_n;
  logic [2:0] bit_cnt, bit_cnt_n, bit_dn;
  logic [PTR_W-1:0] ptr, ptr_n, ptr_inc, wr_addr_n;
  logic full, full_n, rw, rw_n, sda_oe_n, busy_n, wr_strobe_n, we;
  logic rise, fall, start, stop;
  // bit 0 carries SCL, bit 1 carries SDA; idle bus level is high
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      filt <= '1;
      filt_q <= '1;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1 <= {sda_i, scl_i};
      sync2 <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) cnt[i] <= '0;
        else if (cnt[i] == 3'(FILTER_LEN - 1)) begin
          filt[i] <= sync2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 3'd1;
      end
    end
  end
  assign rise = filt[0] & ~filt_q[0];
  assign fall = ~filt[0] & filt_q[0];
  assign start = filt_q[1] & ~filt[1] & filt[0];
  assign stop = ~filt_q[1] & filt[1] & filt[0];
  assign rd_byte = regs[ptr];
  assign bit_dn = bit_cnt - 3'd1;
  assign ptr_inc = (ptr == PTR_W'(NUM_REGS - 1)) ? '0 : ptr + 1'b1;
  assign host_rdata = regs[host_raddr];
  // full marks a completed byte (or a master ACK in MACK) awaiting the next SCL fall
  always_comb begin
    state_n = state;
    bit_cnt_n = bit_cnt;
    shreg_n = shreg;
    full_n = full;
    ptr_n = ptr;
    rw_n = rw;
    sda_oe_n = sda_oe;
    busy_n = busy;
    we = 1'b0;
    wr_strobe_n = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    if (stop) begin
      state_n = IDLE;
      sda_oe_n = 1'b0;
      busy_n = 1'b0;
      full_n = 1'b0;
    end else if (start) begin
      state_n = ADDR;
      bit_cnt_n = 3'd7;
      full_n = 1'b0;
      sda_oe_n = 1'b0;
    end else if (rise && (state == ADDR || state == PTR || state == WDATA)) begin
      shreg_n = {shreg[6:0], filt[1]};
      full_n = bit_cnt == 3'd0;
      bit_cnt_n = bit_dn;
    end else if (rise && state == MACK) begin
      if (filt[1]) begin
        state_n = IDLE;
        sda_oe_n = 1'b0;
        busy_n = 1'b0;
      end else full_n = 1'b1;
    end else if (fall) begin
      case (state)
        ADDR: if (full) begin
          full_n = 1'b0;
          if (shreg[7:1] == SLAVE_ADDR) begin
            state_n = ACK_A;
            sda_oe_n = 1'b1;
            busy_n = 1'b1;
            rw_n = shreg[0];
          end else begin
            state_n = IDLE;
            busy_n = 1'b0;
          end
        end
        ACK_A, MACK: if (state == ACK_A ? rw : full) begin
          state_n = RDATA;
          shreg_n = rd_byte;
          bit_cnt_n = 3'd7;
          sda_oe_n = ~rd_byte[7];
          full_n = 1'b0;
        end else if (state == ACK_A) begin
          state_n = PTR;
          sda_oe_n = 1'b0;
          bit_cnt_n = 3'd7;
        end
        PTR: if (full) begin
          full_n = 1'b0;
          if ({24'd0, shreg} < 32'(NUM_REGS)) begin
            ptr_n = shreg[PTR_W-1:0];
            state_n = ACK_P;
            sda_oe_n = 1'b1;
          end else begin
            state_n = IDLE;
            sda_oe_n = 1'b0;
            busy_n = 1'b0;
          end
        end
        ACK_P, ACK_W: begin
          state_n = WDATA;
          sda_oe_n = 1'b0;
          bit_cnt_n = 3'd7;
        end
        WDATA: if (full) begin
          full_n = 1'b0;
          we = 1'b1;
          wr_strobe_n = 1'b1;
          wr_addr_n = ptr;
          wr_data_n = shreg;
          ptr_n = ptr_inc;
          state_n = ACK_W;
          sda_oe_n = 1'b1;
        end
        RDATA: if (bit_cnt == 3'd0) begin
          sda_oe_n = 1'b0;
          ptr_n = ptr_inc;
          state_n = MACK;
          full_n = 1'b0;
        end else begin
          bit_cnt_n = bit_dn;
          sda_oe_n = ~shreg[bit_dn];
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bit_cnt <= 3'd7;
      shreg <= '0;
      full <= 1'b0;
      ptr <= '0;
      rw <= 1'b0;
      sda_oe <= 1'b0;
      busy <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg <= shreg_n;
      full <= full_n;
      ptr <= ptr_n;
      rw <= rw_n;
      sda_oe <= sda_oe_n;
      busy <= busy_n;
      wr_strobe <= wr_strobe_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    else if (we) regs[ptr] <= shreg;
  end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb_i2c_slave_regfile: bit-banged I2C master with a write-strobe scoreboard and register model.
module tb_i2c_slave_regfile;
  localparam int Q = 10;
  logic clk = 0, rst = 1, scl_m = 1, sda_m = 1, sda_bus;
  logic sda_oe, wr_strobe, busy, ack;
  logic [3:0] host_raddr = 0, wr_addr;
  logic [7:0] host_rdata, wr_data, d;
  logic [11:0] exp_wr[$];
  logic [7:0] mdl[16];
  int n_vec = 0, n_err = 0;
  bit oe_seen;
  assign sda_bus = sda_m & ~sda_oe;
  i2c_slave_regfile dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
    .host_raddr(host_raddr), .host_rdata(host_rdata), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1;
    if (!rst && wr_strobe) begin
      if (exp_wr.size() == 0) chk("wr_spurious", 32'(wr_strobe), 0);
      else chk("wr_strobe", {wr_addr, wr_data}, exp_wr.pop_front());
    end
  end
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wbit(input logic b);
    sda_m = b; tick(Q);
    scl_m = 1; tick(2 * Q);
    scl_m = 0; tick(Q);
  endtask
  task automatic rbit(output logic b);
    sda_m = 1; tick(Q);
    scl_m = 1; tick(Q);
    b = sda_bus; tick(Q);
    scl_m = 0; tick(Q);
  endtask
  task automatic wbyte(input logic [7:0] v, output logic a, input int glitch_at = -1);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      if (i == glitch_at) begin
        scl_m = 1; tick(1);
        scl_m = 0; tick(Q);
      end
      wbit(v[i]);
    end
    rbit(b);
    a = ~b;
  endtask
  task automatic rbyte(output logic [7:0] v, input logic a);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      v[i] = b;
    end
    wbit(~a);
  endtask
  task automatic i2c_start();
    sda_m = 1; tick(Q);
    scl_m = 1; tick(Q);
    sda_m = 0; tick(Q);
    scl_m = 0; tick(Q);
  endtask
  task automatic i2c_stop();
    sda_m = 0; tick(Q);
    scl_m = 1; tick(Q);
    sda_m = 1; tick(Q);
  endtask
  task automatic push(input logic [3:0] a, input logic [7:0] v);
    exp_wr.push_back({a, v});
    mdl[a] = v;
  endtask
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    tick(5);
    chk("rst_sda_oe", 32'(sda_oe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_strobe", 32'(wr_strobe), 0);
    chk("rst_rdata", 32'(host_rdata), 0);
    rst = 0;
    tick(20);
    // write burst at 3
    i2c_start();
    wbyte(8'hAE, ack); chk("wb_addr_ack", 32'(ack), 1);
    chk("wb_busy", 32'(busy), 1);
    wbyte(8'h03, ack); chk("wb_ptr_ack", 32'(ack), 1);
    push(3, 8'h11); wbyte(8'h11, ack); chk("wb_d0_ack", 32'(ack), 1);
    push(4, 8'h22); wbyte(8'h22, ack); chk("wb_d1_ack", 32'(ack), 1);
    i2c_stop(); tick(Q);
    chk("wb_busy_after", 32'(busy), 0);
    host_raddr = 4; tick(1);
    chk("wb_rdata4", 32'(host_rdata), 32'(mdl[4]));
    // burst wrapping 15 -> 0 -> 1
    i2c_start();
    wbyte(8'hAE, ack); wbyte(8'h0F, ack);
    push(15, 8'h5A); wbyte(8'h5A, ack);
    push(0, 8'hA5); wbyte(8'hA5, ack);
    push(1, 8'h3C); wbyte(8'h3C, ack); chk("wrap_ack", 32'(ack), 1);
    i2c_stop(); tick(Q);
    // combined read with repeated start
    i2c_start();
    wbyte(8'hAE, ack); wbyte(8'h0F, ack);
    i2c_start();
    wbyte(8'hAF, ack); chk("rd_addr_ack", 32'(ack), 1);
    rbyte(d, 1); chk("rd_byte15", 32'(d), 32'(mdl[15]));
    rbyte(d, 0); chk("rd_byte0_wrap", 32'(d), 32'(mdl[0]));
    chk("rd_release", 32'(sda_oe), 0);
    i2c_stop(); tick(Q);
    chk("rd_busy_after", 32'(busy), 0);
    // address mismatch
    oe_seen = 0;
    i2c_start();
    wbyte(8'hA0, ack); chk("mm_nack", 32'(ack), 0);
    chk("mm_busy", 32'(busy), 0);
    wbyte(8'h55, ack);
    i2c_stop(); tick(Q);
    chk("mm_oe_never", 32'(oe_seen), 0);
    // invalid pointer
    i2c_start();
    wbyte(8'hAE, ack); wbyte(8'h20, ack); chk("ip_nack", 32'(ack), 0);
    chk("ip_busy", 32'(busy), 0);
    wbyte(8'h77, ack); chk("ip_data_nack", 32'(ack), 0);
    i2c_stop(); tick(Q);
    // read without pointer phase resumes at persisted ptr (1)
    i2c_start();
    wbyte(8'hAF, ack);
    rbyte(d, 0); chk("persist_rd", 32'(d), 32'(mdl[1]));
    i2c_stop(); tick(Q);
    // SCL glitch inside pointer byte
    i2c_start();
    wbyte(8'hAE, ack); wbyte(8'h05, ack, 4); chk("gl_ptr_ack", 32'(ack), 1);
    push(5, 8'h99); wbyte(8'h99, ack);
    i2c_stop(); tick(Q);
    host_raddr = 5; tick(1);
    chk("gl_rdata5", 32'(host_rdata), 32'(mdl[5]));
    // STOP after 4 data bits
    i2c_start();
    wbyte(8'hAE, ack); wbyte(8'h06, ack);
    wbit(1); wbit(0); wbit(1); wbit(0);
    i2c_stop(); tick(Q);
    chk("ab_busy", 32'(busy), 0);
    host_raddr = 6; tick(1);
    chk("ab_rdata6", 32'(host_rdata), 32'(mdl[6]));
    // reset during RDATA of reg 6 (0x00, so SDA is pulled low)
    i2c_start();
    wbyte(8'hAF, ack);
    chk("rr_drive", 32'(sda_oe), 1);
    rst = 1; tick(1);
    chk("rr_release", 32'(sda_oe), 0);
    chk("rr_busy", 32'(busy), 0);
    rst = 0;
    scl_m = 1; sda_m = 1;
    for (int i = 0; i < 16; i++) begin
      mdl[i] = 8'h00;
      host_raddr = 4'(i); tick(1);
      chk($sformatf("rr_reg%0d", i), 32'(host_rdata), 32'(mdl[i]));
    end
    chk("wr_queue_empty", 32'(exp_wr.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
